biriscv_exec_writeback: RTL and testbench
=========================================

// Module: biriscv_exec_writeback
// PURPOSE
//  Writeback stage directly downstream of the integer execute unit.
//  - Captures the registered ALU result with its destination index and PC.
//  - Queues results in a small FIFO and drains them to the register-file write port, which is shared with the LSU.
//  - Backpressures execute through ready_o; the pipeline controller drives the execute hold from ~ready_o.
//  - Reports pending-write hazards and, optionally, forwards pending values to operand read.
// PARAMETERS
//  DEPTH  2  result queue entries; legal values 1..4; need not be a power of two
// PORTS
//  clk_i             in   1   clock
//  rst_ni            in   1   async active-low reset
//  valid_i           in   1   execute result valid; aligned with value_i
//  value_i           in   32  execute writeback value
//  rd_idx_i          in   5   destination register index
//  pc_i              in   32  PC of producing instruction
//  ready_o           out  1   queue can accept this cycle
//  rf_wr_en_o        out  1   register-file write request (head valid)
//  rf_wr_idx_o       out  5   head destination index
//  rf_wr_data_o      out  32  head value
//  rf_wr_ready_i     in   1   write port granted this cycle
//  rf_wr_pc_o        out  32  head PC (trace/debug)
//  ra_idx_i          in   5   operand A index being read at issue
//  rb_idx_i          in   5   operand B index being read at issue
//  fwd_ra_hit_o      out  1   pending write to ra_idx_i
//  fwd_ra_value_o    out  32  youngest pending value for ra_idx_i
//  fwd_rb_hit_o      out  1   as above, operand B
//  fwd_rb_value_o    out  32  as above, operand B
//  level_o           out  3   current queue occupancy
// BEHAVIOUR
//  Interface: one clock, clk_i. Reset is asynchronous, active-low (rst_ni). Polarity and synchronicity are fixed.
//  Reset: queue empty, pointers 0, level_o=0, rf_wr_en_o=0, idx/data/pc outputs 0, ready_o=1 once reset releases.
//   Reset asserted mid-operation discards all entries; nothing is written.
//  Push: valid_i && ready_o. rd_idx_i==0 is accepted but not enqueued (x0 discard).
//  ready_o = (level != DEPTH), driven from registered state only; no combinational path from rf_wr_ready_i.
//  Pop: rf_wr_en_o && rf_wr_ready_i; head advances at the clock edge.
//  Latency: minimum 1 cycle from push to rf_wr_en_o. No same-cycle pass-through.
//  Ordering: strict FIFO; writes leave in push order.
//  Simultaneous push and pop: level unchanged. Only legal when level<DEPTH (ready_o gates the push).
//  Full: ready_o=0; valid_i is ignored and must be held by upstream. Empty: rf_wr_en_o=0.
//  Pointers wrap modulo DEPTH. level width: 3 bits, zero-extended onto level_o.
//  rf_wr_en_o held high with stable idx/data/pc until granted; idx/data/pc are 0 while empty.
//  Hazard: fwd_rX_hit_o=1 if rX_idx_i!=0 and a queued entry has a matching rd (always computed).
//  Register-file write is architecturally visible the cycle after the pop.
// CONFIGURATION
//  BIRISCV_WB_FORWARD_EN defined:
//   - fwd_rX_value_o = value of the youngest matching entry.
//   - An accepted push in the same cycle has highest priority and is included in the hit.
//  BIRISCV_WB_FORWARD_EN undefined:
//   - fwd_rX_value_o tied to 0.
//   - hit excludes the same-cycle push and serves only as an issue-stall request.
// STRUCTURE
//  Shared package (biriscv_defs): constants for register-index width (5) and XLEN (32).
//  One sub-module, biriscv_wb_fifo, holds storage and pointers.
//   - Generic DEPTH x (5+32+32) FIFO with valid/ready on both sides.
//   - Exposes flat entry and valid vectors for the hazard/forward compare.
//  Top level holds x0 filtering, the compare/priority mux and the output mapping.
// TESTING
//  1. Reset: release rst_ni, push rd=5 val=0x1234 while rf_wr_ready_i=1.
//     -> next cycle rf_wr_en_o=1, idx 5, data 0x1234; then empty, level_o=0.
//  2. Backpressure: rf_wr_ready_i=0, push rd=1,2 (DEPTH=2).
//     -> ready_o=0, level_o=2. Raise rf_wr_ready_i -> writes 1 then 2 in order, ready_o=1 after first pop.
//  3. x0: push rd=0 val=0xFFFF -> accepted, level_o stays 0, no rf_wr_en_o.
//  4. Hazard (rf_wr_ready_i=0): queue rd=7 val=0xA, then rd=7 val=0xB; ra_idx_i=7.
//     -> hit=1; value 0xB with macro, 0 without. rb_idx_i=0 -> hit=0.
//  5. Simultaneous push and pop at level 1: level_o stays 1; FIFO order preserved across pointer wrap.
//  6. Reset mid-drain: full queue, assert rst_ni=0 asynchronously.
//     -> rf_wr_en_o=0 immediately, level_o=0, ready_o=1 after release.

Source files
------------

// File: rtl/biriscv_defs_pkg.sv
// Shared definitions for the biriscv writeback slice: register-index and
// XLEN widths, the queued writeback entry layout and pointer helpers.
package biriscv_defs;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  // Queue bounds: DEPTH is legal in 1..4, so two pointer bits and a
  // three-bit occupancy cover every configuration.
  localparam int MAX_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int LEVEL_W   = 3;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      value;
    logic [XLEN-1:0]      pc;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Advance a queue pointer, wrapping modulo depth (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input int depth);
    return (int'(ptr) == depth - 1) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/biriscv_wb_fifo.sv
// Result queue for the writeback stage: DEPTH entries of {idx, value, pc}
// with valid/ready on both sides. Also exposes every entry in age order
// (slot 0 = head/oldest) with a matching valid vector, so the top level can
// search pending writes for hazards and forwarding.
module biriscv_wb_fifo
  import biriscv_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [ENTRY_W-1:0]       in_data_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [ENTRY_W-1:0]       out_data_o,
  input  logic                     out_ready_i,
  output logic [DEPTH*ENTRY_W-1:0] entries_o,
  output logic [DEPTH-1:0]         valid_o,
  output logic [LEVEL_W-1:0]       level_o
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [MAX_DEPTH];
  logic               push;
  logic               pop;

  // Handshake status comes from registered occupancy only.
  assign in_ready_o  = (count_q != LEVEL_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign level_o     = count_q;
  assign out_data_o  = entries_o[ENTRY_W-1:0];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q, DEPTH);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q, DEPTH);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on an accepted push.
  // NOTE: storage has no reset; occupancy gates every read, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  // Age-ordered view of the queue: slot k holds the k-th oldest entry.
  always_comb begin
    logic [LEVEL_W-1:0] slot;
    slot      = '0;
    entries_o = '0;
    valid_o   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = {1'b0, rd_ptr_q} + LEVEL_W'(k);
      if (slot >= LEVEL_W'(DEPTH)) slot = slot - LEVEL_W'(DEPTH);
      entries_o[k*ENTRY_W +: ENTRY_W] = mem_q[slot[PTR_W-1:0]];
      valid_o[k]                      = (LEVEL_W'(k) < count_q);
    end
  end

endmodule

// File: rtl/biriscv_exec_writeback.sv
// Writeback stage behind the integer execute unit. Queues ALU results and
// drains them in order to the shared register-file write port; drops x0
// writes at the input; reports pending-write hazards for operand read.
// Build option: define BIRISCV_WB_FORWARD_EN to forward the youngest pending
// value (including an accepted same-cycle push); otherwise forward values are
// 0 and the hit flags only request an issue stall.
module biriscv_exec_writeback
  import biriscv_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [XLEN-1:0]      value_i,
  input  logic [REG_IDX_W-1:0] rd_idx_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 ready_o,
  output logic                 rf_wr_en_o,
  output logic [REG_IDX_W-1:0] rf_wr_idx_o,
  output logic [XLEN-1:0]      rf_wr_data_o,
  input  logic                 rf_wr_ready_i,
  output logic [XLEN-1:0]      rf_wr_pc_o,
  input  logic [REG_IDX_W-1:0] ra_idx_i,
  input  logic [REG_IDX_W-1:0] rb_idx_i,
  output logic                 fwd_ra_hit_o,
  output logic [XLEN-1:0]      fwd_ra_value_o,
  output logic                 fwd_rb_hit_o,
  output logic [XLEN-1:0]      fwd_rb_value_o,
  output logic [2:0]           level_o
);

  logic                     fifo_in_valid;
  logic [ENTRY_W-1:0]       push_entry;
  logic                     head_valid;
  logic [ENTRY_W-1:0]       head_data;
  wb_entry_t                head;
  logic [DEPTH*ENTRY_W-1:0] entries;
  logic [DEPTH-1:0]         entries_valid;
  logic [LEVEL_W-1:0]       level;
  logic                     push_acc;
  logic [XLEN:0]            ra_res;
  logic [XLEN:0]            rb_res;

  // x0 results are handshaken normally but never enter the queue.
  assign fifo_in_valid = valid_i && (rd_idx_i != '0);
  assign push_entry    = {rd_idx_i, value_i, pc_i};
  assign push_acc      = fifo_in_valid && ready_o;

  biriscv_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (fifo_in_valid),
    .in_data_i   (push_entry),
    .in_ready_o  (ready_o),
    .out_valid_o (head_valid),
    .out_data_o  (head_data),
    .out_ready_i (rf_wr_ready_i),
    .entries_o   (entries),
    .valid_o     (entries_valid),
    .level_o     (level)
  );

  // Register-file write port: head entry, forced to zero while empty.
  assign head         = wb_entry_t'(head_data);
  assign rf_wr_en_o   = head_valid;
  assign rf_wr_idx_o  = head_valid ? head.idx   : '0;
  assign rf_wr_data_o = head_valid ? head.value : '0;
  assign rf_wr_pc_o   = head_valid ? head.pc    : '0;
  assign level_o      = level;

  // Search pending writes for idx; returns {hit, youngest value}.
  function automatic logic [XLEN:0] lookup(input logic [REG_IDX_W-1:0] idx);
    logic            hit;
    logic [XLEN-1:0] val;
    wb_entry_t       e;
    hit = 1'b0;
    val = '0;
    if (idx != '0) begin
      // Scan oldest to youngest so the last match is the youngest.
      for (int k = 0; k < DEPTH; k++) begin
        e = wb_entry_t'(entries[k*ENTRY_W +: ENTRY_W]);
        if (entries_valid[k] && (e.idx == idx)) begin
          hit = 1'b1;
`ifdef BIRISCV_WB_FORWARD_EN
          val = e.value;
`endif
        end
      end
`ifdef BIRISCV_WB_FORWARD_EN
      // The result being accepted this cycle is younger than anything queued.
      if (push_acc && (rd_idx_i == idx)) begin
        hit = 1'b1;
        val = value_i;
      end
`endif
    end
    return {hit, val};
  endfunction

  // Hazard/forward compare for both issue operands.
  always_comb begin
    ra_res = lookup(ra_idx_i);
    rb_res = lookup(rb_idx_i);
  end

  assign fwd_ra_hit_o   = ra_res[XLEN];
  assign fwd_ra_value_o = ra_res[XLEN-1:0];
  assign fwd_rb_hit_o   = rb_res[XLEN];
  assign fwd_rb_value_o = rb_res[XLEN-1:0];

endmodule

// File: tb/tb_biriscv_exec_writeback.sv
// Directed bench for biriscv_exec_writeback (DEPTH=2). Inputs change 1ns
// after the rising edge; outputs are sampled in the same window.
module tb_biriscv_exec_writeback;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] value_i = '0;
  logic [4:0]  rd_idx_i = '0;
  logic [31:0] pc_i = '0;
  logic        ready_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_data_o;
  logic        rf_wr_ready_i = 1'b0;
  logic [31:0] rf_wr_pc_o;
  logic [4:0]  ra_idx_i = '0;
  logic [4:0]  rb_idx_i = '0;
  logic        fwd_ra_hit_o;
  logic [31:0] fwd_ra_value_o;
  logic        fwd_rb_hit_o;
  logic [31:0] fwd_rb_value_o;
  logic [2:0]  level_o;

  int checks = 0;
  int failures = 0;

`ifdef BIRISCV_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  biriscv_exec_writeback #(.DEPTH(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .value_i        (value_i),
    .rd_idx_i       (rd_idx_i),
    .pc_i           (pc_i),
    .ready_o        (ready_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_idx_o    (rf_wr_idx_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .rf_wr_ready_i  (rf_wr_ready_i),
    .rf_wr_pc_o     (rf_wr_pc_o),
    .ra_idx_i       (ra_idx_i),
    .rb_idx_i       (rb_idx_i),
    .fwd_ra_hit_o   (fwd_ra_hit_o),
    .fwd_ra_value_o (fwd_ra_value_o),
    .fwd_rb_hit_o   (fwd_rb_hit_o),
    .fwd_rb_value_o (fwd_rb_value_o),
    .level_o        (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] val,
                       input logic [31:0] pc);
    valid_i  = v;
    rd_idx_i = rd;
    value_i  = val;
    pc_i     = pc;
  endtask

  // Head of queue: enable, index and data in one comparison.
  task automatic expect_head(input string name, input logic en, input logic [4:0] idx,
                             input logic [31:0] data, input logic [2:0] lvl);
    checks++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, level_o} !== {en, idx, data, lvl}) begin
      failures++;
      $display("FAIL %s got en=%0b idx=%0d data=%h level=%0d exp en=%0b idx=%0d data=%h level=%0d",
               name, rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, level_o, en, idx, data, lvl);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    expect_head("rst_state", 1'b0, 5'd0, 32'h0, 3'd0);
    checks++;
    if (rf_wr_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_pc got=%h exp=0", rf_wr_pc_o);
    end
    rst_ni = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%0b exp=1", ready_o);
    end
    rf_wr_ready_i = 1'b1;
    drive(1'b1, 5'd5, 32'h1234, 32'h100);
    // No same-cycle pass-through.
    expect_head("rst_no_passthru", 1'b0, 5'd0, 32'h0, 3'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    expect_head("rst_first_write", 1'b1, 5'd5, 32'h1234, 3'd1);
    checks++;
    if (rf_wr_pc_o !== 32'h100) begin
      failures++;
      $display("FAIL rst_first_pc got=%h exp=100", rf_wr_pc_o);
    end
    step();
    expect_head("rst_drained", 1'b0, 5'd0, 32'h0, 3'd0);
  endtask

  task automatic test_backpressure();
    rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd1, 32'h11, 32'h200);
    step();
    drive(1'b1, 5'd2, 32'h22, 32'h204);
    step();
    // Held valid with a new value while full must be ignored.
    drive(1'b1, 5'd3, 32'h33, 32'h208);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_ready got=%0b exp=0", ready_o);
    end
    expect_head("bp_full", 1'b1, 5'd1, 32'h11, 3'd2);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    expect_head("bp_hold", 1'b1, 5'd1, 32'h11, 3'd2);
    rf_wr_ready_i = 1'b1;
    step();
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after_pop got=%0b exp=1", ready_o);
    end
    expect_head("bp_second", 1'b1, 5'd2, 32'h22, 3'd1);
    step();
    expect_head("bp_empty", 1'b0, 5'd0, 32'h0, 3'd0);
  endtask

  task automatic test_x0();
    rf_wr_ready_i = 1'b1;
    drive(1'b1, 5'd0, 32'hFFFF, 32'h300);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready got=%0b exp=1", ready_o);
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    expect_head("x0_discard", 1'b0, 5'd0, 32'h0, 3'd0);
  endtask

  task automatic test_hazard();
    rf_wr_ready_i = 1'b0;
    ra_idx_i = 5'd7;
    rb_idx_i = 5'd0;
    drive(1'b1, 5'd7, 32'hA, 32'h400);
    step();
    drive(1'b1, 5'd7, 32'hB, 32'h404);
    // Entry A queued, B being accepted this cycle.
    checks++;
    if ({fwd_ra_hit_o, fwd_ra_value_o} !== {1'b1, (FWD ? 32'hB : 32'h0)}) begin
      failures++;
      $display("FAIL hz_push_cycle got hit=%0b val=%h exp hit=1 val=%h",
               fwd_ra_hit_o, fwd_ra_value_o, (FWD ? 32'hB : 32'h0));
    end
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    checks++;
    if ({fwd_ra_hit_o, fwd_ra_value_o} !== {1'b1, (FWD ? 32'hB : 32'h0)}) begin
      failures++;
      $display("FAIL hz_youngest got hit=%0b val=%h exp hit=1 val=%h",
               fwd_ra_hit_o, fwd_ra_value_o, (FWD ? 32'hB : 32'h0));
    end
    checks++;
    if ({fwd_rb_hit_o, fwd_rb_value_o} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL hz_rb_x0 got hit=%0b val=%h exp hit=0 val=0", fwd_rb_hit_o, fwd_rb_value_o);
    end
    rb_idx_i = 5'd8;
    checks++;
    if (fwd_rb_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL hz_rb_nomatch got=%0b exp=0", fwd_rb_hit_o);
    end
    // Push into a different register only when not full; x0 queue check: drain.
    rf_wr_ready_i = 1'b1;
    step();
    expect_head("hz_drain_b", 1'b1, 5'd7, 32'hB, 3'd1);
    step();
    checks++;
    if (fwd_ra_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL hz_cleared got=%0b exp=0", fwd_ra_hit_o);
    end
    ra_idx_i = 5'd0;
    rb_idx_i = 5'd0;
  endtask

  task automatic test_back_to_back();
    rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 32'h500);
    step();
    rf_wr_ready_i = 1'b1;
    // Simultaneous push and pop at level 1, repeated across pointer wraps.
    for (int i = 4; i <= 7; i++) begin
      expect_head("b2b_head", 1'b1, 5'(i - 1), 32'h11 * (i - 1), 3'd1);
      drive(1'b1, 5'(i), 32'h11 * i, 32'h500 + 32'(4 * i));
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    expect_head("b2b_last", 1'b1, 5'd7, 32'h77, 3'd1);
    step();
    expect_head("b2b_empty", 1'b0, 5'd0, 32'h0, 3'd0);
  endtask

  task automatic test_reset_mid();
    rf_wr_ready_i = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 32'h600);
    step();
    drive(1'b1, 5'd10, 32'hAA, 32'h604);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0);
    expect_head("rm_full", 1'b1, 5'd9, 32'h99, 3'd2);
    rf_wr_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    expect_head("rm_async", 1'b0, 5'd0, 32'h0, 3'd0);
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rm_ready got=%0b exp=1", ready_o);
    end
    expect_head("rm_after", 1'b0, 5'd0, 32'h0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_x0();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
